bam_mul_arbiter: RTL and testbench

BAM_MUL_ARBITER -- requirements
Module: bam_mul_arbiter

---
 rtl/bam_mul_arbiter_if.sv | 27 ++
 rtl/bam_mul_arbiter.sv | 128 ++++++++++++
 tb/tb_bam_mul_arbiter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/bam_mul_arbiter_if.sv
// Request/response bundle for bam_mul_arbiter: N_REQ operand ports in,
// one approximate-product response out, plus status.
interface bam_mul_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_a;
  logic [8*N_REQ-1:0] req_b;
  logic [N_REQ-1:0]   req_ready;
  logic               resp_valid;
  logic               resp_ready;
  logic [ID_W-1:0]    resp_id;
  logic [15:0]        resp_prod;
  logic               busy;
  logic [15:0]        op_count;

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_prod, busy, op_count
  );

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_id, resp_prod, busy, op_count
  );
endinterface

// File: rtl/bam_mul_arbiter.sv
// Round-robin arbiter feeding a two-stage pipeline that computes an 8x8
// broken-array approximate product (horizontal cut 2, vertical cut 9).
module bam_mul_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  bam_mul_arbiter_if.slave    bus
);

  // Only partial products a[i]&b[j] with j>=2 and i+j>=9 survive; bit 15 is dropped.
  function automatic logic [15:0] bam_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] acc;
    acc = 16'h0000;
    for (int j = 2; j < 8; j++) begin
      for (int i = 0; i < 8; i++) begin
        if ((i + j >= 9) && a[i] && b[j]) begin
          acc = acc + (16'h0001 << (i + j));
        end else begin
          acc = acc;
        end
      end
    end
    return {1'b0, acc[14:0]};
  endfunction

  logic [ID_W-1:0]  r_ptr;
  logic             r_s1_vld;
  logic [7:0]       r_s1_a;
  logic [7:0]       r_s1_b;
  logic [ID_W-1:0]  r_s1_id;
  logic             r_s2_vld;
  logic [15:0]      r_s2_prod;
  logic [ID_W-1:0]  r_s2_id;
  logic [15:0]      r_op_cnt;

  logic             w_win_vld;
  logic [ID_W-1:0]  w_win_id;
  logic             w_s2_free;
  logic             w_s1_adv;
  logic             w_can_acc;
  logic             w_acc;
  logic [N_REQ-1:0] w_ready;

  // Winner search from r_ptr upward with wrap; lowest offset is applied last so it wins.
  always_comb begin
    w_win_vld = 1'b0;
    w_win_id  = '0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      int idx;
      idx       = (int'(r_ptr) + off) % N_REQ;
      w_win_id  = bus.req_valid[idx] ? ID_W'(idx) : w_win_id;
      w_win_vld = w_win_vld | bus.req_valid[idx];
    end
  end

  // Stall chain: S2 frees on empty/consume, S1 follows, accept follows S1.
  always_comb begin
    w_s2_free = ~r_s2_vld | bus.resp_ready;
    w_s1_adv  = r_s1_vld & w_s2_free;
    w_can_acc = ~r_s1_vld | w_s1_adv;
    w_acc     = w_win_vld & w_can_acc & rst_n;
    if (w_acc) begin
      w_ready = {{(N_REQ-1){1'b0}}, 1'b1} << w_win_id;
    end else begin
      w_ready = '0;
    end
  end

  // Round-robin pointer moves past the winner only on an actual accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_acc) begin
      r_ptr <= (w_win_id == ID_W'(N_REQ - 1)) ? '0 : w_win_id + {{(ID_W-1){1'b0}}, 1'b1};
    end
  end

  // Stage S1: operand capture from the winning requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld <= 1'b0;
      r_s1_a   <= 8'h00;
      r_s1_b   <= 8'h00;
      r_s1_id  <= '0;
    end else if (w_acc) begin
      r_s1_vld <= 1'b1;
      r_s1_a   <= bus.req_a[{w_win_id, 3'b000} +: 8];
      r_s1_b   <= bus.req_b[{w_win_id, 3'b000} +: 8];
      r_s1_id  <= w_win_id;
    end else if (w_s1_adv) begin
      r_s1_vld <= 1'b0;
    end
  end

  // Stage S2: product result held until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_vld  <= 1'b0;
      r_s2_prod <= 16'h0000;
      r_s2_id   <= '0;
    end else if (w_s1_adv) begin
      r_s2_vld  <= 1'b1;
      r_s2_prod <= bam_mul(r_s1_a, r_s1_b);
      r_s2_id   <= r_s1_id;
    end else if (w_s2_free) begin
      r_s2_vld  <= 1'b0;
    end
  end

  // Saturating count of accepted operations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_cnt <= 16'h0000;
    end else if (w_acc && (r_op_cnt != 16'hFFFF)) begin
      r_op_cnt <= r_op_cnt + 16'h0001;
    end
  end

  assign bus.req_ready  = w_ready;
  assign bus.resp_valid = r_s2_vld;
  assign bus.resp_prod  = r_s2_prod;
  assign bus.resp_id    = r_s2_id;
  assign bus.busy       = r_s1_vld | r_s2_vld;
  assign bus.op_count   = r_op_cnt;

endmodule

// File: tb/tb_bam_mul_arbiter.sv
// Randomized + directed bench for bam_mul_arbiter, checked against a
// transaction-level model (2-deep in-flight queue, arithmetic product).
module tb_bam_mul_arbiter;
  localparam int N = 4;

  logic clk;
  logic rst_n;

  bam_mul_arbiter_if #(.N_REQ(N), .ID_W(2)) bif ();

  bam_mul_arbiter #(.N_REQ(N), .ID_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int id;
    int prod;
    bit fresh;
  } item_t;

  item_t q[$];
  int    p;
  int    cnt;
  int    n_vec;
  int    n_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Sum of surviving rows: row j keeps the bits of a at positions >= 9-j.
  function automatic int ref_prod(input int a, input int b);
    int s;
    s = 0;
    for (int j = 2; j < 8; j++) begin
      if (((b >> j) & 1) == 1) s += ((a >> (9 - j)) << (9 - j)) << j;
    end
    return s % 32768;
  endfunction

  function automatic void model_reset();
    q.delete();
    p   = 0;
    cnt = 0;
  endfunction

  task automatic run_cycle(input logic [3:0] v, input logic [31:0] a,
                           input logic [31:0] b, input logic rr);
    int       win;
    bit       head_vis;
    bit       consume;
    bit       acc;
    logic [3:0] exp_ready;
    item_t    it;
    @(negedge clk);
    bif.req_valid  = v;
    bif.req_a      = a;
    bif.req_b      = b;
    bif.resp_ready = rr;
    #1;
    head_vis = (q.size() > 0) && !q[0].fresh;
    consume  = head_vis && rr;
    win = -1;
    for (int off = 0; off < N; off++) begin
      if (win < 0 && v[(p + off) % N]) win = (p + off) % N;
    end
    acc = (win >= 0) && ((q.size() - (consume ? 1 : 0)) < 2);
    exp_ready = acc ? (4'b0001 << win) : 4'b0000;
    chk("req_ready", {28'h0, bif.req_ready}, {28'h0, exp_ready});
    chk("resp_valid", {31'h0, bif.resp_valid}, {31'h0, head_vis});
    if (head_vis) begin
      chk("resp_id", {30'h0, bif.resp_id}, q[0].id);
      chk("resp_prod", {16'h0, bif.resp_prod}, q[0].prod);
    end
    chk("busy", {31'h0, bif.busy}, (q.size() > 0) ? 32'd1 : 32'd0);
    chk("op_count", {16'h0, bif.op_count}, cnt);
    @(posedge clk);
    if (consume) void'(q.pop_front());
    foreach (q[i]) q[i].fresh = 1'b0;
    if (acc) begin
      it.id    = win;
      it.prod  = ref_prod(int'(a[8*win +: 8]), int'(b[8*win +: 8]));
      it.fresh = 1'b1;
      q.push_back(it);
      p = (win + 1) % N;
      if (cnt < 65535) cnt++;
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_req_ready"}, {28'h0, bif.req_ready}, 32'h0);
    chk({tag, "_resp_valid"}, {31'h0, bif.resp_valid}, 32'h0);
    chk({tag, "_resp_id"}, {30'h0, bif.resp_id}, 32'h0);
    chk({tag, "_resp_prod"}, {16'h0, bif.resp_prod}, 32'h0);
    chk({tag, "_busy"}, {31'h0, bif.busy}, 32'h0);
    chk({tag, "_op_count"}, {16'h0, bif.op_count}, 32'h0);
  endtask

  logic [7:0]  spot_a [5] = '{8'hFF, 8'h80, 8'hFF, 8'h0F, 8'h00};
  logic [7:0]  spot_b [5] = '{8'hFF, 8'h80, 8'h04, 8'h0F, 8'hFF};
  logic [15:0] spot_e [5] = '{16'h7000, 16'h4000, 16'h0200, 16'h0000, 16'h0000};

  initial begin
    n_vec = 0;
    n_err = 0;
    model_reset();
    rst_n          = 1'b0;
    bif.req_valid  = 4'hF;
    bif.req_a      = 32'hFFFF_FFFF;
    bif.req_b      = 32'hFFFF_FFFF;
    bif.resp_ready = 1'b1;
    #23;
    check_reset_state("rst");

    // Release between edges so the next rising edge is the first one out of reset.
    bif.req_valid = 4'h0;
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Fairness: all requesters valid, no backpressure.
    for (int i = 0; i < 8; i++) run_cycle(4'hF, $urandom(), $urandom(), 1'b1);
    #2 chk("fair_op_count", {16'h0, bif.op_count}, 32'd8);
    for (int i = 0; i < 3; i++) run_cycle(4'h0, 32'h0, 32'h0, 1'b1);

    // Datapath spot values through requester 0.
    for (int k = 0; k < 5; k++) begin
      run_cycle(4'h1, {24'h0, spot_a[k]}, {24'h0, spot_b[k]}, 1'b1);
      run_cycle(4'h0, 32'h0, 32'h0, 1'b1);
      #2;
      chk("spot_valid", {31'h0, bif.resp_valid}, 32'd1);
      chk("spot_prod", {16'h0, bif.resp_prod}, {16'h0, spot_e[k]});
      chk("spot_id", {30'h0, bif.resp_id}, 32'd0);
      run_cycle(4'h0, 32'h0, 32'h0, 1'b1);
    end

    // Backpressure: consumer stalls for 5 cycles with continuous requests.
    for (int i = 0; i < 5; i++) run_cycle(4'hF, $urandom(), $urandom(), 1'b0);
    #2 chk("bp_req_ready", {28'h0, bif.req_ready}, 32'h0);
    for (int i = 0; i < 6; i++) run_cycle(4'hF, $urandom(), $urandom(), 1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      run_cycle(4'($urandom_range(0, 15)), $urandom(), $urandom(),
                ($urandom_range(0, 3) != 0));
    end

    // Reset while both stages are occupied.
    for (int i = 0; i < 3; i++) run_cycle(4'hF, $urandom(), $urandom(), 1'b0);
    @(negedge clk);
    #2;
    rst_n         = 1'b0;
    bif.req_valid = 4'h0;
    #1;
    check_reset_state("midrst");
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) run_cycle(4'h0, 32'h0, 32'h0, 1'b1);
    for (int i = 0; i < 100; i++) begin
      run_cycle(4'($urandom_range(0, 15)), $urandom(), $urandom(),
                ($urandom_range(0, 1) != 0));
    end

    // Saturation of the accept counter.
    for (int i = 0; i < 65540; i++) run_cycle(4'hF, $urandom(), $urandom(), 1'b1);
    #2 chk("sat_op_count", {16'h0, bif.op_count}, 32'h0000_FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
